// File: rtl/char_writer_pkg.sv
// Shared constants, command/state encodings and nibble helper for char_writer.
// Latency: none (declarations only).
// Backpressure: n/a.
package char_writer_pkg;

    // ASCII bases used by the hex converter and the screen clear
    localparam logic [7:0] ASCII_BLANK   = 8'h20;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;

    // Number of characters printed for one 32-bit word
    localparam int HEX_DIGITS = 8;

    typedef enum logic [1:0] {
        CMD_HEX32 = 2'd0,
        CMD_CHAR  = 2'd1,
        CMD_CLEAR = 2'd2,
        CMD_RSVD  = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HEX   = 2'd1,
        ST_CHAR  = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

    // Nibble idx of a word, counted from the most significant end (idx 0 = [31:28])
    function automatic logic [3:0] nibble_at(input logic [31:0] word, input logic [2:0] idx);
        logic [31:0] shifted;
        shifted = word << {idx, 2'b00};
        return shifted[31:28];
    endfunction

endpackage

// File: rtl/char_writer_if.sv
// Command handshake plus character-buffer write port of char_writer.
// Latency: none (wiring only).
// Backpressure: req_valid/req_ready; the write port has no backpressure.
interface char_writer_if #(
    parameter int ADDR_W = 6
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_cmd;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic              we;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              busy;

    // Command producer: issues requests and observes the buffer write port
    modport master (
        output req_valid, req_cmd, req_addr, req_data,
        input  req_ready, busy, we, wr_addr, wr_data
    );

    // char_writer side: takes commands and drives the buffer write port
    modport slave (
        input  req_valid, req_cmd, req_addr, req_data,
        output req_ready, busy, we, wr_addr, wr_data
    );
endinterface

// File: rtl/char_writer_nib2ascii.sv
// Converts one 4-bit nibble into its ASCII hex digit.
// Latency: purely combinational.
// Backpressure: none.
import char_writer_pkg::*;

module nib2ascii #(
    parameter bit UPPER_HEX = 1'b1
) (
    input  logic [3:0] nib_i,
    output logic [7:0] ascii_o
);

    localparam logic [7:0] ALPHA_BASE = UPPER_HEX ? ASCII_UPPER_A : ASCII_LOWER_A;

    // 0-9 map onto '0'.., 10-15 onto 'A'.. or 'a'..
    always_comb begin
        ascii_o = ASCII_ZERO + {4'h0, nib_i};
        if (nib_i > 4'd9) begin
            ascii_o = ALPHA_BASE + {4'h0, nib_i} - 8'd10;
        end
    end

endmodule

// File: rtl/char_writer.sv
// Serialises HEX32/CHAR/CLEAR commands into one-character-per-cycle buffer writes.
// Latency: first write visible the cycle after acceptance; HEX32 8, CHAR 1, CLEAR 64 writes.
// Backpressure: req_ready low from acceptance until the cycle after the last write; nothing queued.
import char_writer_pkg::*;

module char_writer #(
    parameter int         ADDR_W     = 6,
    parameter logic [7:0] BLANK_CHAR = ASCII_BLANK,
    parameter bit         UPPER_HEX  = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    char_writer_if.slave bus
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    logic              accept;
    logic [2:0]        next_idx;
    logic [3:0]        nib;
    logic [7:0]        nib_ascii;

    assign accept   = bus.req_valid && ready_q;
    assign next_idx = cnt_q[2:0] + 3'd1;

    // In IDLE the first digit comes straight from the request; afterwards from the latched word
    assign nib = (state_q == ST_IDLE) ? bus.req_data[31:28] : nibble_at(data_q, next_idx);

    nib2ascii #(
        .UPPER_HEX (UPPER_HEX)
    ) u_nib2ascii (
        .nib_i   (nib),
        .ascii_o (nib_ascii)
    );

    // Next state and next registered outputs; each state describes the write shown this cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        we_d      = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        ready_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (accept) begin
                    ready_d = 1'b0;
                    addr_d  = bus.req_addr;
                    data_d  = bus.req_data;
                    cnt_d   = '0;
                    case (cmd_e'(bus.req_cmd))
                        CMD_HEX32: begin
                            state_d   = ST_HEX;
                            we_d      = 1'b1;
                            wr_addr_d = bus.req_addr;
                            wr_data_d = nib_ascii;
                        end
                        CMD_CHAR: begin
                            state_d   = ST_CHAR;
                            we_d      = 1'b1;
                            wr_addr_d = bus.req_addr;
                            wr_data_d = bus.req_data[7:0];
                        end
                        CMD_CLEAR: begin
                            state_d   = ST_CLEAR;
                            we_d      = 1'b1;
                            wr_addr_d = '0;
                            wr_data_d = BLANK_CHAR;
                        end
                        // Reserved: swallow it, one not-ready cycle, no write
                        default: ;
                    endcase
                end
            end
            ST_HEX: begin
                if (cnt_q[2:0] == 3'(HEX_DIGITS - 1)) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + ONE;
                    we_d      = 1'b1;
                    wr_addr_d = addr_q + cnt_q + ONE;
                    wr_data_d = nib_ascii;
                end
            end
            ST_CHAR: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            ST_CLEAR: begin
                if (&cnt_q) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d     = cnt_q + ONE;
                    we_d      = 1'b1;
                    wr_addr_d = cnt_q + ONE;
                    wr_data_d = BLANK_CHAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase

        busy_d = ~ready_d;
    end

    // State and output registers; reset abandons any command in progress
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            we_q      <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            we_q      <= we_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.we        = we_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;

endmodule

// File: tb/tb_char_writer.sv
// Directed bench for char_writer: upper-case instance for most steps, lower-case instance for the wrap test.
// Latency: checks are cycle-exact, sampled 1 time unit after each rising edge.
// Backpressure: exercises valid held against req_ready low.
module tb_char_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    char_writer_if #(.ADDR_W(6)) bus_u ();
    char_writer_if #(.ADDR_W(6)) bus_l ();

    char_writer #(.ADDR_W(6), .BLANK_CHAR(8'h20), .UPPER_HEX(1'b1)) dut_u (
        .clk (clk),
        .rst (rst),
        .bus (bus_u)
    );

    char_writer #(.ADDR_W(6), .BLANK_CHAR(8'h20), .UPPER_HEX(1'b0)) dut_l (
        .clk (clk),
        .rst (rst),
        .bus (bus_l)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic req_u(input logic v, input logic [1:0] cmd, input logic [5:0] addr, input logic [31:0] data);
        bus_u.req_valid = v;
        bus_u.req_cmd   = cmd;
        bus_u.req_addr  = addr;
        bus_u.req_data  = data;
    endtask

    initial begin
        logic [7:0] exp_hex1 [8];
        logic [7:0] exp_hex2 [8];
        logic [7:0] exp_hex3 [8];
        logic [5:0] a;

        exp_hex1 = '{8'h44, 8'h45, 8'h41, 8'h44, 8'h42, 8'h45, 8'h45, 8'h46};
        exp_hex2 = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h61, 8'h62, 8'h63, 8'h64};
        exp_hex3 = '{8'h38, 8'h39, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46};

        req_u(1'b0, 2'd0, 6'd0, 32'd0);
        bus_l.req_valid = 1'b0;
        bus_l.req_cmd   = 2'd0;
        bus_l.req_addr  = 6'd0;
        bus_l.req_data  = 32'd0;

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", bus_u.req_ready, 1);
        check("rst_busy", bus_u.busy, 0);
        check("rst_we", bus_u.we, 0);
        check("rst_wr_addr", bus_u.wr_addr, 0);
        check("rst_wr_data", bus_u.wr_data, 0);

        // HEX32 DEADBEEF at 16
        req_u(1'b1, 2'd0, 6'd16, 32'hDEADBEEF);
        tick();
        req_u(1'b0, 2'd0, 6'd0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            a = 6'd16 + 6'(i);
            check("hex1_we", bus_u.we, 1);
            check("hex1_addr", bus_u.wr_addr, a);
            check("hex1_data", bus_u.wr_data, exp_hex1[i]);
            check("hex1_busy", bus_u.busy, 1);
            check("hex1_ready", bus_u.req_ready, 0);
            tick();
        end
        check("hex1_end_we", bus_u.we, 0);
        check("hex1_end_ready", bus_u.req_ready, 1);
        check("hex1_hold_addr", bus_u.wr_addr, 23);
        check("hex1_hold_data", bus_u.wr_data, 8'h46);

        // HEX32 lower-case with address wrap from 62
        bus_l.req_valid = 1'b1;
        bus_l.req_cmd   = 2'd0;
        bus_l.req_addr  = 6'd62;
        bus_l.req_data  = 32'h0123ABCD;
        tick();
        bus_l.req_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a = 6'd62 + 6'(i);
            check("hex2_we", bus_l.we, 1);
            check("hex2_addr", bus_l.wr_addr, a);
            check("hex2_data", bus_l.wr_data, exp_hex2[i]);
            tick();
        end
        check("hex2_end_we", bus_l.we, 0);
        check("hex2_end_ready", bus_l.req_ready, 1);

        // CLEAR, with a second request pulsed mid-clear
        req_u(1'b1, 2'd2, 6'd9, 32'd0);
        tick();
        req_u(1'b0, 2'd0, 6'd0, 32'd0);
        for (int i = 0; i < 64; i++) begin
            a = 6'(i);
            check("clr_we", bus_u.we, 1);
            check("clr_addr", bus_u.wr_addr, a);
            check("clr_data", bus_u.wr_data, 8'h20);
            check("clr_busy", bus_u.busy, 1);
            if (i == 20) req_u(1'b1, 2'd1, 6'd3, 32'h0000_0058);
            if (i == 30) req_u(1'b0, 2'd0, 6'd0, 32'd0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            check("clr_after_we", bus_u.we, 0);
            check("clr_after_busy", bus_u.busy, 0);
            tick();
        end

        // CHAR, reserved, then CHAR held valid through the not-ready cycle
        req_u(1'b1, 2'd1, 6'd5, 32'h0000_004B);
        tick();
        req_u(1'b1, 2'd3, 6'd7, 32'h0000_0077);
        check("char1_we", bus_u.we, 1);
        check("char1_addr", bus_u.wr_addr, 5);
        check("char1_data", bus_u.wr_data, 8'h4B);
        check("char1_ready", bus_u.req_ready, 0);
        tick();
        check("char1_end_we", bus_u.we, 0);
        check("char1_end_ready", bus_u.req_ready, 1);
        tick();
        req_u(1'b1, 2'd1, 6'd6, 32'h0000_0021);
        check("rsvd_we", bus_u.we, 0);
        check("rsvd_ready", bus_u.req_ready, 0);
        tick();
        check("rsvd_end_we", bus_u.we, 0);
        check("rsvd_end_ready", bus_u.req_ready, 1);
        tick();
        req_u(1'b0, 2'd0, 6'd0, 32'd0);
        check("char2_we", bus_u.we, 1);
        check("char2_addr", bus_u.wr_addr, 6);
        check("char2_data", bus_u.wr_data, 8'h21);
        tick();
        check("char2_end_we", bus_u.we, 0);
        check("char2_end_ready", bus_u.req_ready, 1);

        // Reset at the 4th write of a HEX32; rst wins over a pending request
        req_u(1'b1, 2'd0, 6'd32, 32'h12345678);
        tick();
        req_u(1'b0, 2'd0, 6'd0, 32'd0);
        tick();
        tick();
        tick();
        check("hexr_we", bus_u.we, 1);
        check("hexr_addr", bus_u.wr_addr, 35);
        check("hexr_data", bus_u.wr_data, 8'h34);
        rst = 1'b1;
        req_u(1'b1, 2'd1, 6'd0, 32'h0000_0041);
        tick();
        rst = 1'b0;
        check("hexr_rst_we", bus_u.we, 0);
        check("hexr_rst_ready", bus_u.req_ready, 1);
        check("hexr_rst_busy", bus_u.busy, 0);
        check("hexr_rst_addr", bus_u.wr_addr, 0);
        tick();
        req_u(1'b0, 2'd0, 6'd0, 32'd0);
        check("postrst_we", bus_u.we, 1);
        check("postrst_addr", bus_u.wr_addr, 0);
        check("postrst_data", bus_u.wr_data, 8'h41);
        tick();
        check("postrst_end_we", bus_u.we, 0);
        check("postrst_end_ready", bus_u.req_ready, 1);

        // Back-to-back: CHAR then HEX32 held valid, accepted when ready returns
        req_u(1'b1, 2'd1, 6'd10, 32'h0000_0078);
        tick();
        req_u(1'b1, 2'd0, 6'd20, 32'h89ABCDEF);
        check("b2b_char_we", bus_u.we, 1);
        check("b2b_char_addr", bus_u.wr_addr, 10);
        check("b2b_char_data", bus_u.wr_data, 8'h78);
        tick();
        check("b2b_gap_we", bus_u.we, 0);
        check("b2b_gap_ready", bus_u.req_ready, 1);
        tick();
        req_u(1'b0, 2'd0, 6'd0, 32'd0);
        for (int i = 0; i < 8; i++) begin
            a = 6'd20 + 6'(i);
            check("b2b_hex_we", bus_u.we, 1);
            check("b2b_hex_addr", bus_u.wr_addr, a);
            check("b2b_hex_data", bus_u.wr_data, exp_hex3[i]);
            tick();
        end
        check("b2b_end_we", bus_u.we, 0);
        check("b2b_end_ready", bus_u.req_ready, 1);
        check("b2b_end_busy", bus_u.busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/char_writer.md
Name: char_writer

Overview:
- Write-side master for the 64-character OLED text buffer.
- Accepts one command at a time over a valid/ready handshake: hex-dump a 32-bit word, write a single character, or clear the screen.
- Serialises each command into one-character-per-cycle writes on the buffer's we/wr_addr/data write port.
- Sits between the pipeline debug/status logic and the character buffer feeding the OLED controller.

Parameters:
- ADDR_W, 6, character address width; buffer depth is 2**ADDR_W = 64 (4 rows x 16 columns).
- BLANK_CHAR, 8'h20, fill character used by CLEAR.
- UPPER_HEX, 1, 1: hex digits A-F map to 8'h41-8'h46; 0: they map to 8'h61-8'h66.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- req_valid  input  1  command present
- req_ready  output  1  block can accept a command
- req_cmd  input  2  0=HEX32, 1=CHAR, 2=CLEAR, 3=reserved
- req_addr  input  ADDR_W  start character address (ignored by CLEAR)
- req_data  input  32  HEX32: word to print; CHAR: [7:0] is the character
- we  output  1  buffer write enable
- wr_addr  output  ADDR_W  buffer write address
- wr_data  output  8  buffer write data
- busy  output  1  command in progress (equal to ~req_ready)

Behaviour:
- Clock and reset: single clock domain; reset is synchronous and active-high.
- Reset values: req_ready=1, busy=0, we=0, wr_addr=0, wr_data=0, state=IDLE.
- Outputs: all outputs are registered; there is no combinational path from req_* to we, wr_addr or wr_data.
- Handshake: a command is accepted on the rising edge where req_valid && req_ready. At that edge the block latches cmd, addr and data, and req_ready drops to 0. req_valid while req_ready=0 is ignored; nothing is queued.
- States: IDLE, HEX, CHAR, CLEAR.
- IDLE:
  - Accept HEX32 -> HEX with cnt=0.
  - Accept CHAR -> CHAR.
  - Accept CLEAR -> CLEAR with cnt=0 and address 0.
  - Accept reserved -> stay in IDLE. req_ready is low for exactly one cycle, no write is issued.
- HEX:
  - Each cycle: we=1, wr_addr=start+cnt (mod 64), wr_data=ascii(nibble), most significant nibble first (data[31:28] at start).
  - Conversion: 0-9 -> 8'h30+n; 10-15 -> 8'h41+(n-10), or 8'h61+(n-10) when UPPER_HEX=0.
  - cnt increments 0..7. After the cnt=7 write, go to IDLE.
- CHAR: one write with we=1, wr_addr=addr, wr_data=data[7:0]; then IDLE.
- CLEAR: 64 writes of BLANK_CHAR to addresses 0..63 in ascending order; then IDLE.
- Latency: acceptance at edge N -> first write presented after edge N (visible in cycle N+1).
  - HEX32 writes occupy cycles N+1..N+8.
  - CHAR writes in cycle N+1.
  - CLEAR writes occupy cycles N+1..N+64.
- Return to ready: we returns to 0 and req_ready to 1 in the cycle after the last write. Back-to-back accept is therefore possible in that cycle.
- Address wrap: address arithmetic is modulo 2**ADDR_W. A HEX32 starting at 60 writes addresses 60,61,62,63,0,1,2,3.
- we=0 cycles: wr_addr and wr_data hold their last values.
- Reset mid-operation: the command is abandoned. we=0 and req_ready=1 after the reset edge; the partial buffer contents are left as written.
- Simultaneous events: rst has priority over acceptance. req_valid during the return-to-IDLE cycle is accepted normally.

Decomposition:
- Shared constants go in char_def.v (BLANK_CHAR, ASCII '0'/'A'/'a' bases) and state_def.v (CMD_HEX32, CMD_CHAR, CMD_CLEAR, state encodings for IDLE/HEX/CHAR/CLEAR).
- One combinational sub-module, nib2ascii (4-bit nibble in, 8-bit ASCII out, UPPER_HEX parameter), instantiated once.
- Top-level integration: char_writer drives char_test's we/wr_addr/din directly in place of the external WE_IP/WRITE_ADDR_IP/WRITE_DATA_IP pins.

Test Plan:
- After reset, HEX32 with addr=16, data=32'hDEADBEEF -> writes 'D','E','A','D','B','E','E','F' (8'h44,45,41,44,42,45,45,46) to addresses 16..23 in cycles N+1..N+8; req_ready=1 in cycle N+9.
- HEX32 with addr=62, data=32'h0123ABCD, UPPER_HEX=0 -> addresses 62,63,0,1,2,3,4,5 receive 8'h30,31,32,33,61,62,63,64.
- CLEAR -> exactly 64 writes of 8'h20 to addresses 0..63 in ascending order; busy is high for 64 cycles; a second req_valid asserted mid-clear produces no extra writes.
- CHAR with addr=5, data[7:0]=8'h4B, then reserved cmd, then CHAR with addr=6, data=8'h21 held valid continuously -> exactly two writes ((5,4B) and (6,21)); the reserved command produces one not-ready cycle and no write.
- Assert rst at the 4th write of a HEX32 -> we=0 and req_ready=1 on the next cycle; a subsequent CHAR with addr=0, data=8'h41 completes normally.
- Back-to-back: CHAR accepted, req_valid held high with a new HEX32 -> the HEX32 is accepted in the cycle req_ready returns; total elapsed time is 1+1+8+1 cycles to idle.
